h2f_pio_csr: RTL and testbench
==============================

# h2f_pio_csr

Parametrised parallel-I/O register block on the fabric side of the lightweight HPS-to-FPGA bridge. It gives the HPS software-visible control of NUM_CH channels of fabric outputs and inputs. Each channel has synchronised input sampling, configurable edge capture and a maskable, level-sensitive interrupt to the HPS. It is the channelised, interrupt-capable successor to the fixed pinless HPS top: it adds the first fabric-side peripheral behind the bridge.

## Interface
Parameters:
- NUM_CH, 4: number of channels, 1..16.
- DW, 32: channel data width, 1..32.
- EDGE_MODE, 0: edge capture mode. 0 = rising, 1 = falling, 2 = both.
- OUT_RST, 0: reset value of every DATA_OUT register, DW bits.
- ID_VAL, 32'h5046_494F: value of the ID register.

Ports:
- clk, in, 1: bridge clock. All logic is single-clock.
- reset_n, in, 1: reset, synchronous, active-low.
- avs_address, in, $clog2(NUM_CH)+3: word address.
- avs_read, in, 1: read request.
- avs_write, in, 1: write request.
- avs_writedata, in, 32: write data.
- avs_byteenable, in, 4: byte lanes for writes.
- avs_readdata, out, 32: read data.
- avs_readdatavalid, out, 1: read data qualifier.
- avs_waitrequest, out, 1: accept stall. Always 0; no stalls are generated.
- pio_in, in, NUM_CH*DW: asynchronous inputs. Channel c occupies bits [c*DW +: DW].
- pio_out, out, NUM_CH*DW: registered outputs.
- irq, out, 1: level interrupt to the HPS.

## Operation
- Address decode: if avs_address MSB = 1, the block-global space is selected:
  - Offset 0: ID (RO).
  - Offset 1: NUM_CH (RO).
  - Offset 2: IRQ_PEND (RO), bit c = |(EDGE_CAP[c] & IRQ_MASK[c]).
  - All other global offsets read 0.
- Otherwise the channel space is selected: channel = address[high:2], register = address[1:0].
  - 0: DATA_OUT, RW.
  - 1: DATA_IN, RO, synchronised value.
  - 2: EDGE_CAP, W1C.
  - 3: IRQ_MASK, RW.
- Channel index ≥ NUM_CH: reads return 0; writes are ignored.
- Bits above DW: read 0; writes to them are ignored.
- Writes are per byte lane via avs_byteenable, for RW and W1C registers alike.
- Writes to RO registers are ignored.
- Input path, per channel: 2-flop synchroniser (sync1 → sync2), then a prev register. The edge vector is derived from sync2 vs prev according to EDGE_MODE.
- Arm counter: a 2-bit counter starts at 0 on reset and saturates at 3. Edge capture is enabled only when the count is 3. This suppresses false edges while the synchroniser fills after reset.
- EDGE_CAP update, per bit: next = (cap & ~w1c_clear) | edge. Capture has priority over a simultaneous W1C clear.
- irq = registered OR of all IRQ_PEND bits.
- Simultaneous avs_read and avs_write: the write is performed, and the read returns the pre-write value.

## Timing
- Reset values:
  - avs_readdata = 0, avs_readdatavalid = 0, avs_waitrequest = 0.
  - pio_out = OUT_RST on every channel.
  - irq = 0.
  - All EDGE_CAP, IRQ_MASK, sync1, sync2 and prev registers = 0.
  - Arm counter = 0.
- Read latency is fixed at 1 cycle. For a read accepted at edge n, avs_readdatavalid = 1 and avs_readdata are valid for exactly one cycle after edge n. Back-to-back reads are supported, one per cycle.
- Write: the register updates at the accepting edge. pio_out reflects the new value from that edge (0 extra cycles).
- Input latency, with pin change setup before edge 0:
  - sync1 updates at edge 0 and sync2 at edge 1.
  - EDGE_CAP sets at edge 2.
  - irq asserts at edge 3, if masked-in.
  - DATA_IN readable from edge 1.
- Clearing: a W1C of the last pending masked bit at edge n drops irq at edge n+1. A mask write to 0 behaves the same.
- Reset mid-transaction: an accepted read whose data phase coincides with reset_n = 0 produces no readdatavalid. All state returns to its reset values at that edge.
- Arm window: pin edges reaching sync2 before the arm count is 3 are not captured. The first capturable edge is at the 3rd clock after reset_n rises.

## Test plan
- Reset with pio_in all-ones and OUT_RST = 32'hA5: pio_out = A5 per channel; EDGE_CAP all 0 after 10 cycles; irq stays 0.
- Write 32'h1234_5678 to ch2 DATA_OUT with byteenable 4'b0011, then read → readdata = 32'h0000_5678 with readdatavalid exactly 1 cycle after the read; other channels unchanged.
- EDGE_MODE = 0, ch1 mask = 1: pio_in ch1 bit0 rises → EDGE_CAP ch1 = 1 at edge 2, irq = 1 at edge 3; W1C 1 clears it and irq = 0 the next cycle.
- W1C on ch0 bit3 issued in the same cycle that a new rising edge is detected on bit3 → bit3 remains 1 and irq remains 1.
- Read of global offset 0 → ID_VAL; read of channel index NUM_CH → 0; write to DATA_IN → no change.
- EDGE_MODE = 2: toggle one input 4 times with mask 0 → EDGE_CAP set, irq stays 0; then set the mask → irq = 1 one cycle after the mask write.

Source files
------------

// File: rtl/h2f_pio_csr.sv
// h2f_pio_csr: channelised parallel-I/O register block behind the lightweight
// HPS-to-FPGA bridge. Per channel: a registered output word, a synchronised
// input word, edge capture (W1C) and an interrupt mask. The level interrupt
// is the registered OR of every masked pending capture bit.
module h2f_pio_csr #(
  parameter int              NUM_CH    = 4,
  parameter int              DW        = 32,
  parameter int              EDGE_MODE = 0,
  parameter logic [DW-1:0]   OUT_RST   = {DW{1'b0}},
  parameter logic [31:0]     ID_VAL    = 32'h5046_494F
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [$clog2(NUM_CH)+2:0]    avs_address,
  input  logic                         avs_read,
  input  logic                         avs_write,
  input  logic [31:0]                  avs_writedata,
  input  logic [3:0]                   avs_byteenable,
  output logic [31:0]                  avs_readdata,
  output logic                         avs_readdatavalid,
  output logic                         avs_waitrequest,
  input  logic [NUM_CH*DW-1:0]         pio_in,
  output logic [NUM_CH*DW-1:0]         pio_out,
  output logic                         irq
);

  localparam int          AW       = $clog2(NUM_CH) + 3;
  localparam int          OW       = AW - 1;
  localparam logic [31:0] NUM_CH_U = 32'(NUM_CH);
  localparam logic [1:0]  MODE     = 2'(EDGE_MODE);

  // Expand the four byte enables into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  logic              glob_s;
  logic [OW-1:0]     off_s;
  logic [OW-1:0]     chan_s;
  logic [1:0]        reg_s;
  logic              chan_ok_s;
  logic [31:0]       lanes_s;
  logic [DW-1:0]     wmask_s;
  logic [DW-1:0]     wdata_s;
  logic              unused_s;

  logic [DW-1:0]     data_out_r [NUM_CH];
  logic [DW-1:0]     mask_r     [NUM_CH];
  logic [DW-1:0]     cap_r      [NUM_CH];
  logic [DW-1:0]     sync1_r    [NUM_CH];
  logic [DW-1:0]     sync2_r    [NUM_CH];
  logic [DW-1:0]     prev_r     [NUM_CH];
  logic [DW-1:0]     edge_s     [NUM_CH];
  logic [DW-1:0]     clr_s      [NUM_CH];
  logic [31:0]       rd_ch_s    [NUM_CH];
  logic [NUM_CH-1:0] wr_s;
  logic [NUM_CH-1:0] pend_s;
  logic [1:0]        arm_r;
  logic              armed_s;
  logic [31:0]       rdata_s;
  logic [31:0]       rdata_r;
  logic              rvalid_r;
  logic              irq_r;

  assign glob_s    = avs_address[AW-1];
  assign off_s     = avs_address[OW-1:0];
  assign chan_s    = off_s >> 2;
  assign reg_s     = avs_address[1:0];
  assign chan_ok_s = 32'(chan_s) < NUM_CH_U;
  assign lanes_s   = lane_mask(avs_byteenable);
  assign wmask_s   = lanes_s[DW-1:0];
  assign wdata_s   = avs_writedata[DW-1:0];
  assign unused_s  = ^{avs_writedata, lanes_s};
  assign armed_s   = (arm_r == 2'd3);

  // Per-channel write strobes, W1C clear masks, pending bits and edge vectors.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wr_s[c]   = avs_write & ~glob_s & chan_ok_s & (chan_s == OW'(c));
      clr_s[c]  = (wr_s[c] && (reg_s == 2'd2)) ? (wdata_s & wmask_s) : {DW{1'b0}};
      pend_s[c] = |(cap_r[c] & mask_r[c]);
      edge_s[c] = {DW{1'b0}};
      case (MODE)
        2'd0:    edge_s[c] = sync2_r[c] & ~prev_r[c];
        2'd1:    edge_s[c] = ~sync2_r[c] & prev_r[c];
        2'd2:    edge_s[c] = sync2_r[c] ^ prev_r[c];
        default: edge_s[c] = {DW{1'b0}};
      endcase
      // Edges seen while the synchroniser is still filling are not real.
      if (!armed_s) begin
        edge_s[c] = {DW{1'b0}};
      end else begin
        edge_s[c] = edge_s[c];
      end
    end
  end

  // Per-channel read words, zero-extended above DW.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      case (reg_s)
        2'd0:    rd_ch_s[c] = 32'(data_out_r[c]);
        2'd1:    rd_ch_s[c] = 32'(sync2_r[c]);
        2'd2:    rd_ch_s[c] = 32'(cap_r[c]);
        2'd3:    rd_ch_s[c] = 32'(mask_r[c]);
        default: rd_ch_s[c] = 32'h0000_0000;
      endcase
    end
  end

  // Read data multiplexer across global and channel space.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (glob_s) begin
      case (off_s)
        OW'(0):  rdata_s = ID_VAL;
        OW'(1):  rdata_s = NUM_CH_U;
        OW'(2):  rdata_s = 32'(pend_s);
        default: rdata_s = 32'h0000_0000;
      endcase
    end else if (chan_ok_s) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rdata_s = rdata_s | ((chan_s == OW'(c)) ? rd_ch_s[c] : 32'h0000_0000);
      end
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // One-cycle read response; sampled before any same-cycle write lands.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_r  <= 32'h0000_0000;
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= avs_read;
      rdata_r  <= avs_read ? rdata_s : 32'h0000_0000;
    end
  end

  // Input synchroniser, previous-value register and post-reset arm counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sync1_r[c] <= {DW{1'b0}};
        sync2_r[c] <= {DW{1'b0}};
        prev_r[c]  <= {DW{1'b0}};
      end
      arm_r <= 2'd0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        sync1_r[c] <= pio_in[c*DW +: DW];
        sync2_r[c] <= sync1_r[c];
        prev_r[c]  <= sync2_r[c];
      end
      arm_r <= armed_s ? 2'd3 : arm_r + 2'd1;
    end
  end

  // Channel registers: byte-lane writes, and capture winning over W1C.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        data_out_r[c] <= OUT_RST;
        mask_r[c]     <= {DW{1'b0}};
        cap_r[c]      <= {DW{1'b0}};
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_s[c] && (reg_s == 2'd0)) begin
          data_out_r[c] <= (data_out_r[c] & ~wmask_s) | (wdata_s & wmask_s);
        end else begin
          data_out_r[c] <= data_out_r[c];
        end
        if (wr_s[c] && (reg_s == 2'd3)) begin
          mask_r[c] <= (mask_r[c] & ~wmask_s) | (wdata_s & wmask_s);
        end else begin
          mask_r[c] <= mask_r[c];
        end
        cap_r[c] <= (cap_r[c] & ~clr_s[c]) | edge_s[c];
      end
    end
  end

  // Registered level interrupt.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |pend_s;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign pio_out[g*DW +: DW] = data_out_r[g];
  end

  assign avs_readdata      = rdata_r;
  assign avs_readdatavalid = rvalid_r;
  assign avs_waitrequest   = 1'b0;
  assign irq               = irq_r;

endmodule

// File: tb/tb_h2f_pio_csr.sv
// Bench for h2f_pio_csr: two instances (rising-edge and both-edge capture)
// share one bus and pin stimulus; a register-level model predicts both and is
// compared every cycle, alongside hand-computed expectations.
module tb_h2f_pio_csr;
  localparam int NCH = 3;
  localparam int DW  = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [47:0] pio_in;
  logic [31:0] rd0, rd1;
  logic        rv0, rv1, wq0, wq1, irq0, irq1;
  logic [47:0] po0, po1;

  int n_tot  = 0;
  int n_pass = 0;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  h2f_pio_csr #(.NUM_CH(NCH), .DW(DW), .EDGE_MODE(0), .OUT_RST(16'h00A5)) u0 (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(rd0), .avs_readdatavalid(rv0), .avs_waitrequest(wq0),
    .pio_in(pio_in), .pio_out(po0), .irq(irq0));

  h2f_pio_csr #(.NUM_CH(NCH), .DW(DW), .EDGE_MODE(2), .OUT_RST(16'h00A5)) u1 (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(rd1), .avs_readdatavalid(rv1), .avs_waitrequest(wq1),
    .pio_in(pio_in), .pio_out(po1), .irq(irq1));

  // ---------------- behavioural model ----------------
  logic [15:0] m_out  [NCH];
  logic [15:0] m_mask [NCH];
  logic [15:0] m_cap  [2][NCH];
  logic [47:0] pin_d1, pin_d2, pin_d3;   // pins as sampled 1, 2 and 3 edges ago
  int          since;                    // clocks since reset released, capped
  logic        m_rv;
  logic [31:0] m_rd  [2];
  logic        m_irq [2];

  function automatic logic [2:0] m_pend(input int i);
    logic [2:0] p;
    for (int ch = 0; ch < NCH; ch++) p[ch] = |(m_cap[i][ch] & m_mask[ch]);
    return p;
  endfunction

  function automatic logic [31:0] m_read(input int i, input logic [4:0] a);
    int ch;
    ch = int'(a[3:2]);
    if (a[4]) begin
      if (a[3:0] == 4'd0) return 32'h5046_494F;
      if (a[3:0] == 4'd1) return NCH;
      if (a[3:0] == 4'd2) return {29'd0, m_pend(i)};
      return 32'd0;
    end
    if (ch >= NCH) return 32'd0;
    if (a[1:0] == 2'd0) return {16'd0, m_out[ch]};
    if (a[1:0] == 2'd1) return {16'd0, pin_d2[ch*16 +: 16]};
    if (a[1:0] == 2'd2) return {16'd0, m_cap[i][ch]};
    return {16'd0, m_mask[ch]};
  endfunction

  always @(posedge clk) begin
    logic [15:0] s2, pv, e, bm, d;
    int ch;
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_out[c] = 16'h00A5; m_mask[c] = 16'h0; m_cap[0][c] = 16'h0; m_cap[1][c] = 16'h0;
      end
      pin_d1 = 48'h0; pin_d2 = 48'h0; pin_d3 = 48'h0; since = 0;
      m_rv = 1'b0; m_irq[0] = 1'b0; m_irq[1] = 1'b0;
    end else begin
      m_rv = avs_read;
      for (int i = 0; i < 2; i++) begin
        m_rd[i]  = m_read(i, avs_address);
        m_irq[i] = (m_pend(i) != 3'b000);
      end
      bm = {{8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
      d  = avs_writedata[15:0];
      ch = int'(avs_address[3:2]);
      if (avs_write && !avs_address[4] && ch < NCH) begin
        if (avs_address[1:0] == 2'd0) m_out[ch]  = (m_out[ch] & ~bm) | (d & bm);
        if (avs_address[1:0] == 2'd3) m_mask[ch] = (m_mask[ch] & ~bm) | (d & bm);
        if (avs_address[1:0] == 2'd2) begin
          m_cap[0][ch] = m_cap[0][ch] & ~(d & bm);
          m_cap[1][ch] = m_cap[1][ch] & ~(d & bm);
        end
      end
      for (int c = 0; c < NCH; c++) begin
        s2 = pin_d2[c*16 +: 16];
        pv = pin_d3[c*16 +: 16];
        e  = (since >= 3) ? (s2 & ~pv) : 16'h0;            // rising
        m_cap[0][c] = m_cap[0][c] | e;
        e  = (since >= 3) ? (s2 ^ pv) : 16'h0;             // either direction
        m_cap[1][c] = m_cap[1][c] | e;
      end
      pin_d3 = pin_d2; pin_d2 = pin_d1; pin_d1 = pio_in;
      if (since < 3) since++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("pio_out_m0", po0, {m_out[2], m_out[1], m_out[0]});
      chk("pio_out_m2", po1, {m_out[2], m_out[1], m_out[0]});
      chk("irq_m0", irq0, m_irq[0]);
      chk("irq_m2", irq1, m_irq[1]);
      chk("rvalid_m0", rv0, m_rv);
      chk("rvalid_m2", rv1, m_rv);
      chk("waitreq", {wq0, wq1}, 2'b00);
      if (m_rv) begin
        chk("rdata_m0", rd0, m_rd[0]);
        chk("rdata_m2", rd1, m_rd[1]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus(input logic rd, input logic wr, input logic [4:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = d; avs_byteenable = be;
    tick();
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic rd_lit(input string nm, input logic [4:0] a,
                        input logic [31:0] e0, input logic [31:0] e1);
    bus(1'b1, 1'b0, a, 32'h0, 4'h0);
    chk({nm, "_m0"}, rd0, e0);
    chk({nm, "_m2"}, rd1, e1);
    chk({nm, "_rv"}, rv0, 1'b1);
  endtask

  function automatic logic [4:0] caddr(input int ch, input int r);
    return {1'b0, 2'(ch), 2'(r)};
  endfunction

  function automatic logic [4:0] gaddr(input int o);
    return {1'b1, 4'(o)};
  endfunction

  initial begin
    reset_n = 1'b0; avs_read = 1'b0; avs_write = 1'b0; avs_address = 5'd0;
    avs_writedata = 32'h0; avs_byteenable = 4'h0; pio_in = {48{1'b1}};
    tick(); chk_on = 1'b1; tick(); tick();
    chk("rst_pio", po0, {3{16'h00A5}});
    chk("rst_irq", irq0, 1'b0);
    chk("rst_rv", rv0, 1'b0);
    reset_n = 1'b1;
    repeat (10) tick();
    chk("rst_irq_late", {irq0, irq1}, 2'b00);
    for (int c = 0; c < NCH; c++) rd_lit("cap_after_rst", caddr(c, 2), 32'h0, 32'h0);

    // byte-lane write, read latency
    bus(1'b0, 1'b1, caddr(2, 0), 32'h1234_5678, 4'b0011);
    chk("pio_ch2", po0[47:32], 16'h5678);
    rd_lit("ch2_out", caddr(2, 0), 32'h0000_5678, 32'h0000_5678);
    tick();
    chk("rv_one_cycle", rv0, 1'b0);
    chk("pio_other", po0[31:0], 32'h00A5_00A5);

    // falling edges only captured by the both-edge instance
    pio_in = 48'h0; repeat (5) tick();
    rd_lit("fall_cap", caddr(0, 2), 32'h0, 32'hFFFF);
    for (int c = 0; c < NCH; c++) bus(1'b0, 1'b1, caddr(c, 2), 32'hFFFF, 4'hF);
    tick();

    // rising edge on ch1 bit0 with mask set
    bus(1'b0, 1'b1, caddr(1, 3), 32'h1, 4'h1);
    pio_in[16] = 1'b1;
    tick(); tick(); tick();
    chk("irq_edge2", irq0, 1'b0);
    tick();
    chk("irq_edge3", {irq0, irq1}, 2'b11);
    rd_lit("cap_ch1", caddr(1, 2), 32'h1, 32'h1);
    bus(1'b0, 1'b1, caddr(1, 2), 32'h1, 4'h1);
    chk("irq_w1c_same", irq0, 1'b1);
    tick();
    chk("irq_w1c_next", {irq0, irq1}, 2'b00);

    // capture wins over a simultaneous W1C on ch0 bit3
    bus(1'b0, 1'b1, caddr(0, 3), 32'h8, 4'h1);
    pio_in[3] = 1'b1; repeat (4) tick();
    chk("irq_bit3", irq0, 1'b1);
    pio_in[3] = 1'b0; repeat (4) tick();
    pio_in[3] = 1'b1; tick(); tick();
    bus(1'b0, 1'b1, caddr(0, 2), 32'h8, 4'h1);
    tick();
    chk("irq_prio", {irq0, irq1}, 2'b11);
    rd_lit("cap_prio", caddr(0, 2), 32'h8, 32'h8);

    // global space, out-of-range channel, RO writes, bits above DW
    rd_lit("id", gaddr(0), 32'h5046_494F, 32'h5046_494F);
    rd_lit("num_ch", gaddr(1), 32'd3, 32'd3);
    rd_lit("pend", gaddr(2), 32'h1, 32'h1);
    rd_lit("gbl_other", gaddr(5), 32'h0, 32'h0);
    rd_lit("chan_oob", caddr(3, 0), 32'h0, 32'h0);
    bus(1'b0, 1'b1, caddr(3, 0), 32'hFFFF, 4'hF);
    bus(1'b0, 1'b1, caddr(0, 1), 32'hFFFF, 4'hF);
    rd_lit("data_in", caddr(0, 1), 32'h0008, 32'h0008);
    chk("pio_after_ro", po0, {16'h5678, 16'h00A5, 16'h00A5});
    bus(1'b0, 1'b1, caddr(1, 3), 32'hFFFF_0001, 4'hF);
    rd_lit("mask_hi", caddr(1, 3), 32'h1, 32'h1);

    // simultaneous read and write returns the old value
    bus(1'b1, 1'b1, caddr(1, 0), 32'h0000_BEEF, 4'h3);
    chk("rw_pre", rd0, 32'h0000_00A5);
    rd_lit("rw_post", caddr(1, 0), 32'h0000_BEEF, 32'h0000_BEEF);

    // mask write to 0 drops irq one cycle later
    bus(1'b0, 1'b1, caddr(0, 3), 32'h0, 4'h1);
    chk("irq_unmask_same", irq0, 1'b1);
    tick();
    chk("irq_unmask_next", {irq0, irq1}, 2'b00);

    // toggle ch2 bit5 four times with mask 0, then unmask
    for (int k = 0; k < 4; k++) begin
      pio_in[37] = ~pio_in[37];
      repeat (4) tick();
    end
    chk("irq_masked", {irq0, irq1}, 2'b00);
    rd_lit("toggle_cap", caddr(2, 2), 32'h20, 32'h20);
    bus(1'b0, 1'b1, caddr(2, 3), 32'h20, 4'h1);
    chk("irq_mask_same", irq1, 1'b0);
    tick();
    chk("irq_mask_next", {irq0, irq1}, 2'b11);

    // reset coinciding with a read; arm window after release
    reset_n = 1'b0;
    bus(1'b1, 1'b0, gaddr(0), 32'h0, 4'h0);
    chk("rst_read_rv", {rv0, rv1}, 2'b00);
    chk("rst_read_pio", po0, {3{16'h00A5}});
    tick();
    chk("rst_read_irq", {irq0, irq1}, 2'b00);
    reset_n = 1'b1;
    repeat (6) tick();
    rd_lit("arm_cap", caddr(0, 2), 32'h0, 32'h0);
    rd_lit("arm_cap1", caddr(1, 2), 32'h0, 32'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
